// File: rtl/hazard_unit_if.sv
// Hazard-unit bus: ID/EX/MEM/WB hazard inputs from the pipeline and controller,
// plus the enables, flushes, forwarding selects and counters driven back.
interface hazard_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_regwrite;
  logic              redirect;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rd, ex_memread, ex_regwrite,
    output mem_rd, mem_regwrite, mem_memread,
    output wb_rd, wb_regwrite, redirect,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
    input  fwd_a, fwd_b, state, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rd, ex_memread, ex_regwrite,
    input  mem_rd, mem_regwrite, mem_memread,
    input  wb_rd, wb_regwrite, redirect,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
    output fwd_a, fwd_b, state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall / MEM-redirect flush sequencer with EX operand forwarding.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush event counters.
module hazard_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ex_rs_q, ex_rt_q;
  logic              ex_use_a_q, ex_use_b_q;

  logic       lu_c;
  logic       pc_write_c, ifid_write_c;
  logic       ifid_flush_c, idex_flush_c, exmem_flush_c;
  logic       stall_evt_c, flush_evt_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // ex_regwrite is part of the controller interface but not needed for any decision
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = bus.ex_regwrite;

  // ID holds a bubble while in FLUSH, so no load-use is possible then
  always_comb begin
    lu_c = 1'b0;
    if (bus.ex_memread && (bus.ex_rd != ADDR_W'(0)) && (state_q != ST_FLUSH)) begin
      lu_c = (bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
             (bus.id_uses_rt && (bus.id_rt == bus.ex_rd));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Priority: reset > redirect > load-use > advance
  always_comb begin
    state_d       = ST_RUN;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    stall_evt_c   = 1'b0;
    flush_evt_c   = 1'b0;
    if (!rst) begin
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_flush_c = 1'b1;
    end else if (bus.redirect) begin
      ifid_flush_c  = 1'b1;
      idex_flush_c  = 1'b1;
      exmem_flush_c = 1'b1;
      flush_evt_c   = 1'b1;
      state_d       = ST_FLUSH;
    end else if (lu_c) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_flush_c  = 1'b1;
      stall_evt_c   = 1'b1;
      state_d       = ST_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_use_a_q <= 1'b0;
      ex_use_b_q <= 1'b0;
    end else if (idex_flush_c) begin
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_use_a_q <= 1'b0;
      ex_use_b_q <= 1'b0;
    end else begin
      ex_rs_q    <= bus.id_rs;
      ex_rt_q    <= bus.id_rt;
      ex_use_a_q <= bus.id_uses_rs;
      ex_use_b_q <= bus.id_uses_rt;
    end
  end

  // MEM beats WB; a load in MEM has no data yet; $0 never forwards
  function automatic logic [1:0] fwd_sel(input logic use_x, input logic [ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_x && (src != ADDR_W'(0))) begin
      if (bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == src)) sel = 2'd1;
      else if (bus.wb_regwrite && (bus.wb_rd == src))                  sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_c = fwd_sel(ex_use_a_q, ex_rs_q);
    fwd_b_c = fwd_sel(ex_use_b_q, ex_rt_q);
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (flush_evt_c && (flush_count_q != {CNT_W{1'b1}}))
        flush_count_q <= flush_count_q + CNT_W'(1);
      if (stall_evt_c && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;
`else
  logic unused_evt;
  assign unused_evt      = stall_evt_c ^ flush_evt_c;
  assign bus.stall_count = CNT_W'(0);
  assign bus.flush_count = CNT_W'(0);
`endif

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_flush  = idex_flush_c;
  assign bus.exmem_flush = exmem_flush_c;
  assign bus.fwd_a       = fwd_a_c;
  assign bus.fwd_b       = fwd_b_c;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (CNT_W = 4 to reach saturation).
module tb_hazard_unit;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_stall;
  int   exp_flush;

  hazard_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hif ();

  hazard_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef HAZ_PERF_CNT_EN
    return (v > 15) ? 15 : v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic idle();
    hif.id_rs = '0;        hif.id_rt = '0;
    hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
    hif.ex_rd = '0;        hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0;
    hif.mem_rd = '0;       hif.mem_regwrite = 1'b0; hif.mem_memread = 1'b0;
    hif.wb_rd = '0;        hif.wb_regwrite = 1'b0;
    hif.redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [ADDR_W-1:0] r);
    hif.ex_rd = r; hif.ex_memread = 1'b1; hif.ex_regwrite = 1'b1;
    hif.id_rs = r; hif.id_uses_rs = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; exp_stall = 0; exp_flush = 0;
    rst = 1'b0;
    idle();
    #2;
    check("rst_state", int'(hif.state), 0);
    check("rst_pc_write", int'(hif.pc_write), 1);
    check("rst_ifid_write", int'(hif.ifid_write), 1);
    check("rst_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 7);
    check("rst_fwd", int'({hif.fwd_a, hif.fwd_b}), 0);
    check("rst_counts", int'({hif.stall_count, hif.flush_count}), 0);
    #10 rst = 1'b1;
    tick();
    check("run_state", int'(hif.state), 0);
    check("run_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 0);

    // no stall: $0 destination, and operand not actually read
    set_lu(5'd0); #1;
    check("lu_r0_pc_write", int'(hif.pc_write), 1);
    set_lu(5'd8); hif.id_uses_rs = 1'b0; #1;
    check("lu_unused_pc_write", int'(hif.pc_write), 1);
    idle();
    hif.ex_rd = 5'd8; hif.ex_memread = 1'b1; hif.id_rt = 5'd8; hif.id_uses_rt = 1'b1; #1;
    check("lu_rt_pc_write", int'(hif.pc_write), 0);
    idle(); #1;

    // load-use stall, then WB forwarding to the consumer
    set_lu(5'd8); #1;
    check("lu_pc_write", int'(hif.pc_write), 0);
    check("lu_ifid_write", int'(hif.ifid_write), 0);
    check("lu_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 2);
    tick(); exp_stall++;
    hif.ex_rd = '0; hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0;
    hif.mem_rd = 5'd8; hif.mem_regwrite = 1'b1; hif.mem_memread = 1'b1; #1;
    check("stall_state", int'(hif.state), 1);
    check("stall_count_1", int'(hif.stall_count), cnt_exp(exp_stall));
    check("stall_bubble_fwd_a", int'(hif.fwd_a), 0);
    check("stall_pc_write", int'(hif.pc_write), 1);
    tick();
    hif.mem_rd = '0; hif.mem_regwrite = 1'b0; hif.mem_memread = 1'b0;
    hif.wb_rd = 5'd8; hif.wb_regwrite = 1'b1; #1;
    check("after_stall_state", int'(hif.state), 0);
    check("lu_fwd_a_wb", int'(hif.fwd_a), 2);
    check("lu_fwd_b", int'(hif.fwd_b), 0);

    // redirect beats load-use
    idle(); set_lu(5'd9); hif.redirect = 1'b1; #1;
    check("redir_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 7);
    check("redir_pc_write", int'(hif.pc_write), 1);
    check("redir_ifid_write", int'(hif.ifid_write), 1);
    tick(); exp_flush++;
    hif.redirect = 1'b0; #1;
    check("flush_state", int'(hif.state), 2);
    check("flush_count_1", int'(hif.flush_count), cnt_exp(exp_flush));
    check("flush_stall_unchanged", int'(hif.stall_count), cnt_exp(exp_stall));
    check("flush_lu_masked", int'(hif.pc_write), 1);
    hif.redirect = 1'b1;
    tick(); exp_flush++;
    hif.redirect = 1'b0; idle(); #1;
    check("reflush_state", int'(hif.state), 2);
    check("flush_count_2", int'(hif.flush_count), cnt_exp(exp_flush));
    tick();
    check("flush_done_state", int'(hif.state), 0);

    // forwarding priority with ex_rs = ex_rt = 5
    hif.id_rs = 5'd5; hif.id_uses_rs = 1'b1; hif.id_rt = 5'd5; hif.id_uses_rt = 1'b1;
    tick();
    hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1; hif.wb_rd = 5'd5; hif.wb_regwrite = 1'b1; #1;
    check("fwd_a_mem", int'(hif.fwd_a), 1);
    check("fwd_b_mem", int'(hif.fwd_b), 1);
    hif.mem_memread = 1'b1; #1;
    check("fwd_a_load_in_mem", int'(hif.fwd_a), 2);
    hif.mem_memread = 1'b0; hif.wb_regwrite = 1'b0; hif.mem_regwrite = 1'b0; #1;
    check("fwd_a_none", int'(hif.fwd_a), 0);
    hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
    hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; #1;
    check("fwd_a_r0", int'(hif.fwd_a), 0);

    // bubble inserted by a stall clears forwarding
    idle(); set_lu(5'd5); hif.id_rt = 5'd5; hif.id_uses_rt = 1'b1;
    tick(); exp_stall++;
    idle(); hif.wb_rd = 5'd5; hif.wb_regwrite = 1'b1; #1;
    check("bubble_fwd", int'({hif.fwd_a, hif.fwd_b}), 0);
    check("bubble_stall_count", int'(hif.stall_count), cnt_exp(exp_stall));

    // back-to-back stalls saturate the counter
    idle();
    for (int i = 0; i < 20; i++) begin
      set_lu(ADDR_W'(1 + (i % 30)));
      tick(); exp_stall++;
    end
    check("sat_state", int'(hif.state), 1);
    check("sat_stall_count", int'(hif.stall_count), cnt_exp(exp_stall));

    // asynchronous reset mid-STALL
    #3 rst = 1'b0; #1;
    check("arst_state", int'(hif.state), 0);
    check("arst_pc_write", int'(hif.pc_write), 1);
    check("arst_flushes", int'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 7);
    check("arst_counts", int'({hif.stall_count, hif.flush_count}), 0);
    check("arst_fwd", int'({hif.fwd_a, hif.fwd_b}), 0);
    idle();
    #10 rst = 1'b1;
    tick();
    check("post_rst_state", int'(hif.state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core (IF, ID, EX, MEM, WB). EX is stage 2, MEM is stage 3, WB is stage 4.
- Detects load-use hazards and stalls IF/ID with a one-cycle bubble.
- Squashes younger stages when a branch or jump resolves taken in MEM.
- Drives EX-operand forwarding selects from its own pipelined copies of rs/rt.
- Sits beside the Controller: consumes its staged RegWrite/MemRead/PCsrc signals and drives pipeline-register enables and flushes.

Parameters:
- ADDR_W, 5: register-index width.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  ADDR_W each  source register indices of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_rd  in  ADDR_W  destination of the EX instruction, after the RegDest mux.
- ex_memread, ex_regwrite  in  1 each  EX-stage controls.
- mem_rd  in  ADDR_W; mem_regwrite, mem_memread  in  1 each  MEM-stage destination and controls.
- wb_rd  in  ADDR_W; wb_regwrite  in  1  WB-stage destination and write enable.
- redirect  in  1  PC redirect resolved in MEM (Controller PCsrc, excluding reset).
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register.
- fwd_a, fwd_b  out  2 each  EX operand select: 0 = register file, 1 = MEM result, 2 = WB result.
- state  out  2  0 = RUN, 1 = STALL, 2 = FLUSH.
- stall_count, flush_count  out  CNT_W each  event counters.

Behaviour:
- Reset (rst = 0), asynchronous:
  - state = RUN; internal ex_rs, ex_rt, ex_use_a, ex_use_b = 0; both counters = 0.
  - While rst is low: pc_write = 1, ifid_write = 1, all three flushes = 1, fwd_a = fwd_b = 0.
  - Reset asserted mid-stall or mid-flush aborts that operation immediately.
- Load-use condition (lu), combinational:
  - ex_memread & ex_rd != 0 & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
  - Forced to 0 when state = FLUSH, because ID holds a bubble.
- Priority, same cycle: redirect > lu > normal advance.
- redirect = 1:
  - ifid_flush = idex_flush = exmem_flush = 1.
  - pc_write = 1, ifid_write = 1.
  - Next state = FLUSH; flush_count increments. Any lu in that cycle is ignored and not counted.
- lu = 1 and redirect = 0:
  - pc_write = 0, ifid_write = 0, idex_flush = 1, other flushes = 0.
  - Next state = STALL; stall_count increments.
- Otherwise: pc_write = ifid_write = 1, all flushes = 0, next state = RUN.
- STALL lasts exactly one cycle. The load then sits in MEM, and the consumer reaches EX while the load is in WB. A new lu in the STALL cycle (a different load) produces another stall.
- FLUSH lasts one cycle unless redirect is asserted again.
- Internal ID/EX copy, updated on each clock edge:
  - If idex_flush = 1: ex_rs, ex_rt, ex_use_a, ex_use_b <= 0.
  - Else: <= id_rs, id_rt, id_uses_rs, id_uses_rt.
- Forwarding, combinational, for fwd_a (fwd_b identical using ex_rt / ex_use_b):
  - fwd_a = 1 if ex_use_a & mem_regwrite & ~mem_memread & mem_rd != 0 & mem_rd == ex_rs.
  - Else fwd_a = 2 if ex_use_a & wb_regwrite & wb_rd != 0 & wb_rd == ex_rs.
  - Else fwd_a = 0. MEM takes priority over WB. Register 0 never forwards.
- Counters saturate at all-ones and never wrap.

Optional Feature:
- HAZ_PERF_CNT_EN defined: stall_count and flush_count behave as above.
- Not defined: counter registers are not built, and stall_count and flush_count are tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Load-use stall: lw $8 in EX (ex_rd = 8, ex_memread = 1); add in ID with id_rs = 8, id_uses_rs = 1. Required: in that cycle pc_write = 0, ifid_write = 0, idex_flush = 1; next cycle state = 1; the cycle after, fwd_a = 2 with the add in EX. stall_count = 1.
- Redirect beats stall: redirect = 1 in the same cycle as lu. Required: all three flushes = 1, pc_write = 1, next state = 2, flush_count = 1, stall_count unchanged.
- Forwarding priority: ex_rs = 5; mem_rd = 5 with mem_regwrite = 1; wb_rd = 5 with wb_regwrite = 1. Required: fwd_a = 1. Same with mem_memread = 1: required fwd_a = 2. With rd = 0 in both stages: required fwd_a = 0.
- Bubble clears forwarding: after an idex_flush, the EX bubble gives fwd_a = fwd_b = 0 even though wb_rd matches the old id_rs.
- Saturation, with HAZ_PERF_CNT_EN and CNT_W = 4: 20 stalls give stall_count = 15. Without the macro: stall_count = 0.
- Async reset mid-STALL: drive rst = 0 between clock edges. Required immediately: state = 0, pc_write = 1, all flushes = 1, counters = 0.
